// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite slave to NSLV-way APB3 bridge with wait states, slave/decode errors
// and an optional ACCESS-phase watchdog. Every AHB/APB output is a flop.
module ahb_apb_bridge_param #(
    parameter int unsigned         ADDR_W       = 32,
    parameter int unsigned         DATA_W       = 32,
    parameter int unsigned         NSLV         = 3,
    parameter logic [ADDR_W-1:0]   BASE_ADDR    = ADDR_W'(32'h8000_0000),
    parameter int unsigned         REGION_SHIFT = 26,
    parameter int unsigned         TIMEOUT      = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hreadyin,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic [1:0]        hresp,
    output logic              hreadyout,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [NSLV-1:0]   pselx,
    output logic              penable
);

    localparam int unsigned IDX_W    = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WDOG_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t              r_state, w_nxt_state;
    logic [IDX_W-1:0]    r_idx, w_nxt_idx;
    logic [CNT_W-1:0]    r_wdog, w_nxt_wdog;
    logic [DATA_W-1:0]   r_hrdata, w_nxt_hrdata;
    logic [1:0]          r_hresp, w_nxt_hresp;
    logic                r_hreadyout, w_nxt_hreadyout;
    logic [ADDR_W-1:0]   r_paddr, w_nxt_paddr;
    logic [DATA_W-1:0]   r_pwdata, w_nxt_pwdata;
    logic                r_pwrite, w_nxt_pwrite;
    logic [NSLV-1:0]     r_pselx, w_nxt_pselx;
    logic                r_penable, w_nxt_penable;

    logic [ADDR_W-1:0]   w_offset, w_region;
    logic                w_hit, w_accept;
    logic [IDX_W-1:0]    w_idx;
    logic                w_unused_htrans0;

    assign w_unused_htrans0 = htrans[0];

    // Address decode: region index relative to the APB window base
    assign w_offset = haddr - BASE_ADDR;
    assign w_region = w_offset >> REGION_SHIFT;
    assign w_hit    = (haddr >= BASE_ADDR) && (w_region < ADDR_W'(NSLV));
    assign w_idx    = IDX_W'(w_region);
    assign w_accept = hreadyin && htrans[1] && r_hreadyout
                   && (r_state inside {S_IDLE, S_DONE, S_ERR2});

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_idx    = r_idx;
        w_nxt_wdog   = r_wdog;
        w_nxt_hrdata = r_hrdata;
        w_nxt_paddr  = r_paddr;
        w_nxt_pwdata = r_pwdata;
        w_nxt_pwrite = r_pwrite;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_nxt_idx    = w_idx;
                        w_nxt_paddr  = haddr;
                        w_nxt_pwrite = hwrite;
                        w_nxt_state  = hwrite ? S_WDATA : S_SETUP;
                    end else begin
                        w_nxt_state  = S_ERR1;
                    end
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_WDATA: begin
                w_nxt_pwdata = hwdata;
                w_nxt_state  = S_SETUP;
            end
            S_SETUP: begin
                w_nxt_wdog  = '0;
                w_nxt_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_nxt_wdog = '0;
                    if (pslverr) begin
                        w_nxt_state = S_ERR1;
                    end else begin
                        w_nxt_state = S_DONE;
                        if (!r_pwrite) w_nxt_hrdata = prdata;
                    end
                end else if ((TIMEOUT != 0) && (r_wdog == CNT_W'(WDOG_LIM))) begin
                    w_nxt_wdog  = '0;
                    w_nxt_state = S_ERR1;
                end else begin
                    w_nxt_wdog = r_wdog + CNT_W'(1);
                end
            end
            S_ERR1:  w_nxt_state = S_ERR2;
            default: w_nxt_state = S_IDLE;
        endcase

        // Bus-visible outputs are a pure function of the state being entered
        w_nxt_hreadyout = w_nxt_state inside {S_IDLE, S_DONE, S_ERR2};
        w_nxt_hresp     = (w_nxt_state inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
        w_nxt_pselx     = (w_nxt_state inside {S_SETUP, S_ACCESS})
                        ? (NSLV'(1) << w_nxt_idx) : '0;
        w_nxt_penable   = (w_nxt_state == S_ACCESS);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_wdog      <= '0;
            r_hrdata    <= '0;
            r_hresp     <= 2'b00;
            r_hreadyout <= 1'b1;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_wdog      <= w_nxt_wdog;
            r_hrdata    <= w_nxt_hrdata;
            r_hresp     <= w_nxt_hresp;
            r_hreadyout <= w_nxt_hreadyout;
            r_paddr     <= w_nxt_paddr;
            r_pwdata    <= w_nxt_pwdata;
            r_pwrite    <= w_nxt_pwrite;
            r_pselx     <= w_nxt_pselx;
            r_penable   <= w_nxt_penable;
        end
    end

    assign hrdata    = r_hrdata;
    assign hresp     = r_hresp;
    assign hreadyout = r_hreadyout;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pwrite    = r_pwrite;
    assign pselx     = r_pselx;
    assign penable   = r_penable;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed bench: cycle table for reads/misses/back-to-back, plus hand-written
// sequences for wait states, slave error, watchdog and async reset.
module tb_ahb_apb_bridge_param;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic [31:0] hrdata, paddr, pwdata;
    logic [1:0]  hresp;
    logic        hreadyout, pwrite, penable;
    logic [2:0]  pselx;

    logic [31:0] n_hrdata, n_paddr, n_pwdata;
    logic [1:0]  n_hresp;
    logic        n_hreadyout, n_pwrite, n_penable;
    logic [2:0]  n_pselx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 hclk = ~hclk;

    ahb_apb_bridge_param #(.TIMEOUT(4)) u_dut (
        .hclk(hclk), .hresetn(hresetn), .hreadyin(hreadyin), .htrans(htrans),
        .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
        .hresp(hresp), .hreadyout(hreadyout), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .pselx(pselx), .penable(penable)
    );

    ahb_apb_bridge_param #(.TIMEOUT(0)) u_nowd (
        .hclk(hclk), .hresetn(hresetn), .hreadyin(hreadyin), .htrans(htrans),
        .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hrdata(n_hrdata),
        .hresp(n_hresp), .hreadyout(n_hreadyout), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .paddr(n_paddr), .pwdata(n_pwdata), .pwrite(n_pwrite),
        .pselx(n_pselx), .penable(n_penable)
    );

    typedef struct {
        logic        hreadyin;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic [31:0] e_hrdata;
        logic [31:0] e_paddr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic rin, input logic [1:0] tr, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic pr,
                         input logic pe, input logic [31:0] pd);
        hreadyin = rin; htrans = tr; hwrite = wr; haddr = a;
        hwdata = wd; pready = pr; pslverr = pe; prdata = pd;
    endtask

    task automatic add(input logic rin, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic pr, input logic [31:0] pd,
                       input logic er, input logic [1:0] eresp, input logic [2:0] eps,
                       input logic epen, input logic [31:0] ehr, input logic [31:0] epa);
        vec_t v;
        v.hreadyin = rin; v.htrans = tr; v.hwrite = wr; v.haddr = a;
        v.pready = pr; v.pslverr = 1'b0; v.prdata = pd;
        v.e_rdy = er; v.e_resp = eresp; v.e_psel = eps; v.e_pen = epen;
        v.e_hrdata = ehr; v.e_paddr = epa;
        vecs.push_back(v);
    endtask

    initial begin
        // Each row: outputs expected during the cycle, then inputs presented in it.
        //  rin tr     wr   haddr          prdy prdata         rdy resp  psel    pen hrdata         paddr
        add(1, 2'b10, 0, 32'h8400_0010, 1, 32'hDEAD_BEEF, 1, 2'b00, 3'b000, 0, 32'h0,         32'h0);
        add(1, 2'b00, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 2'b00, 3'b010, 0, 32'h0,         32'h8400_0010);
        add(1, 2'b00, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 2'b00, 3'b010, 1, 32'h0,         32'h8400_0010);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0,         1, 2'b00, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b10, 1, 32'h8C00_0000, 1, 32'h0,         1, 2'b00, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0,         0, 2'b01, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0,         1, 2'b01, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b10, 0, 32'h7FFF_FFFC, 1, 32'h0,         1, 2'b00, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0,         0, 2'b01, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b10, 0, 32'h8000_0008, 1, 32'hA5A5_0001, 1, 2'b01, 3'b000, 0, 32'hDEAD_BEEF, 32'h8400_0010);
        add(1, 2'b00, 0, 32'h0,         1, 32'hA5A5_0001, 0, 2'b00, 3'b001, 0, 32'hDEAD_BEEF, 32'h8000_0008);
        add(1, 2'b00, 0, 32'h0,         1, 32'hA5A5_0001, 0, 2'b00, 3'b001, 1, 32'hDEAD_BEEF, 32'h8000_0008);
        add(1, 2'b10, 0, 32'h8800_0000, 1, 32'h0BAD_F00D, 1, 2'b00, 3'b000, 0, 32'hA5A5_0001, 32'h8000_0008);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0BAD_F00D, 0, 2'b00, 3'b100, 0, 32'hA5A5_0001, 32'h8800_0000);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0BAD_F00D, 0, 2'b00, 3'b100, 1, 32'hA5A5_0001, 32'h8800_0000);
        add(1, 2'b01, 0, 32'h8000_0000, 1, 32'h0,         1, 2'b00, 3'b000, 0, 32'h0BAD_F00D, 32'h8800_0000);
        add(0, 2'b10, 0, 32'h8000_0000, 1, 32'h0,         1, 2'b00, 3'b000, 0, 32'h0BAD_F00D, 32'h8800_0000);
        add(1, 2'b00, 0, 32'h0,         1, 32'h0,         1, 2'b00, 3'b000, 0, 32'h0BAD_F00D, 32'h8800_0000);

        hresetn = 1'b0;
        drive(1, 2'b00, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        repeat (2) tick();
        check("rst_hreadyout", 32'(hreadyout), 32'h1);
        check("rst_hresp",     32'(hresp),     32'h0);
        check("rst_pselx",     32'(pselx),     32'h0);
        check("rst_penable",   32'(penable),   32'h0);
        check("rst_pwrite",    32'(pwrite),    32'h0);
        check("rst_paddr",     paddr,          32'h0);
        check("rst_pwdata",    pwdata,         32'h0);
        check("rst_hrdata",    hrdata,         32'h0);
        hresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("v%0d_hreadyout", i), 32'(hreadyout), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d_hresp", i),     32'(hresp),     32'(vecs[i].e_resp));
            check($sformatf("v%0d_pselx", i),     32'(pselx),     32'(vecs[i].e_psel));
            check($sformatf("v%0d_penable", i),   32'(penable),   32'(vecs[i].e_pen));
            check($sformatf("v%0d_hrdata", i),    hrdata,         vecs[i].e_hrdata);
            check($sformatf("v%0d_paddr", i),     paddr,          vecs[i].e_paddr);
            drive(vecs[i].hreadyin, vecs[i].htrans, vecs[i].hwrite, vecs[i].haddr,
                  32'h0, vecs[i].pready, vecs[i].pslverr, vecs[i].prdata);
            tick();
        end

        // Write to slave 2 with two APB wait states
        drive(1, 2'b10, 1, 32'h8800_0004, 32'h0, 0, 0, 32'h0);
        tick();
        check("wr_wdata_rdy",  32'(hreadyout), 32'h0);
        check("wr_wdata_psel", 32'(pselx),     32'h0);
        drive(1, 2'b00, 0, 32'h0, 32'h1234_5678, 0, 0, 32'h0);
        tick();
        check("wr_setup_psel",   32'(pselx),   32'h4);
        check("wr_setup_pen",    32'(penable), 32'h0);
        check("wr_setup_pwrite", 32'(pwrite),  32'h1);
        check("wr_setup_pwdata", pwdata,       32'h1234_5678);
        drive(1, 2'b00, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wr_acc%0d_pen", k),    32'(penable),   32'h1);
            check($sformatf("wr_acc%0d_psel", k),   32'(pselx),     32'h4);
            check($sformatf("wr_acc%0d_paddr", k),  paddr,          32'h8800_0004);
            check($sformatf("wr_acc%0d_pwdata", k), pwdata,         32'h1234_5678);
            check($sformatf("wr_acc%0d_rdy", k),    32'(hreadyout), 32'h0);
            pready = (k == 2);
            tick();
        end
        check("wr_done_rdy",    32'(hreadyout), 32'h1);
        check("wr_done_resp",   32'(hresp),     32'h0);
        check("wr_done_psel",   32'(pselx),     32'h0);
        check("wr_done_pen",    32'(penable),   32'h0);
        check("wr_done_pwdata", pwdata,         32'h1234_5678);
        check("wr_done_hrdata", hrdata,         32'h0BAD_F00D);
        drive(1, 2'b00, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        tick();

        // Read that ends in a slave error
        drive(1, 2'b10, 0, 32'h8000_0000, 32'h0, 1, 1, 32'hFFFF_FFFF);
        tick();
        htrans = 2'b00;
        check("se_setup_psel", 32'(pselx), 32'h1);
        tick();
        check("se_access_pen", 32'(penable), 32'h1);
        tick();
        check("se_err1_rdy",  32'(hreadyout), 32'h0);
        check("se_err1_resp", 32'(hresp),     32'h1);
        check("se_err1_psel", 32'(pselx),     32'h0);
        check("se_err1_pen",  32'(penable),   32'h0);
        pslverr = 1'b0;
        tick();
        check("se_err2_rdy",    32'(hreadyout), 32'h1);
        check("se_err2_resp",   32'(hresp),     32'h1);
        check("se_err2_hrdata", hrdata,         32'h0BAD_F00D);
        tick();
        check("se_idle_resp", 32'(hresp), 32'h0);

        // Stuck slave: watchdog instance errors out, the other one waits
        drive(1, 2'b10, 0, 32'h8400_0000, 32'h0, 0, 0, 32'h0);
        tick();
        htrans = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wd_acc%0d_pen", k), 32'(penable), 32'h1);
            tick();
        end
        check("wd_err1_rdy",  32'(hreadyout), 32'h0);
        check("wd_err1_resp", 32'(hresp),     32'h1);
        check("wd_err1_psel", 32'(pselx),     32'h0);
        check("wd_err1_pen",  32'(penable),   32'h0);
        for (int k = 0; k < 96; k++) begin
            check("nowd_hold", {29'h0, n_hreadyout, n_penable, n_pselx == 3'b010},
                  32'h3);
            tick();
        end
        pready = 1'b1;
        prdata = 32'hCAFE_0001;
        tick();
        check("nowd_done_rdy",    32'(n_hreadyout), 32'h1);
        check("nowd_done_hrdata", n_hrdata,         32'hCAFE_0001);
        check("wd_idle_hrdata",   hrdata,           32'h0BAD_F00D);
        tick();

        // Async reset in the middle of an ACCESS phase
        drive(1, 2'b10, 0, 32'h8000_0004, 32'h0, 0, 0, 32'h0);
        tick();
        htrans = 2'b00;
        tick();
        check("ar_access_pen", 32'(penable), 32'h1);
        #2 hresetn = 1'b0;
        #1;
        check("ar_pselx",     32'(pselx),       32'h0);
        check("ar_penable",   32'(penable),     32'h0);
        check("ar_hreadyout", 32'(hreadyout),   32'h1);
        check("ar_hrdata",    hrdata,           32'h0);
        check("ar_paddr",     paddr,            32'h0);
        check("ar_n_pselx",   32'(n_pselx),     32'h0);
        check("ar_n_hresp",   32'(n_hresp),     32'h0);
        check("ar_n_paddr",   n_paddr,          32'h0);
        check("ar_n_pwdata",  n_pwdata,         32'h0);
        check("ar_n_pwrite",  32'(n_pwrite),    32'h0);
        tick();
        hresetn = 1'b1;
        tick();
        check("ar_after_rdy", 32'(hreadyout), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
